hnm_test_sequencer: RTL and testbench

Synthesizable, parametrised command sequencer that drives the HNM read/write ports with built-in test patterns, replacing hand-coded bench stimulus so the same patterns run on hardware under ILA capture. It generates one HNM command per unstalled cycle, honours the HNM busy flag, and holds a loadable SSID list. It sits between a control source (bench, VIO or host register) and the HNMPP command inputs.

---
 rtl/hnm_test_sequencer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_hnm_test_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hnm_test_sequencer.sv
// Built-in pattern sequencer for the HNM command ports: issues one command per
// unstalled cycle from a selectable test pattern or a loadable SSID list.
module hnm_test_sequencer #(
    parameter int NROWS      = 16,
    parameter int NCOLS      = 16,
    parameter int ROWBITS    = 4,
    parameter int COLBITS    = 4,
    parameter int SSIDBITS   = 8,
    parameter int LISTDEPTH  = 32,
    parameter int LISTBITS   = 5,
    parameter int SWEEP_LAST = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic                  abort,
    input  logic                  hnm_busy,
    input  logic                  list_wr_en,
    input  logic [LISTBITS-1:0]   list_wr_addr,
    input  logic [SSIDBITS-1:0]   list_wr_data,
    input  logic [LISTBITS:0]     list_len,
    output logic                  row_rd,
    output logic [ROWBITS-1:0]    row_rd_idx,
    output logic                  row_wr,
    output logic [ROWBITS-1:0]    row_wr_idx,
    output logic [NCOLS-1:0]      row_wr_data,
    output logic                  ssid_wr,
    output logic [SSIDBITS-1:0]   ssid_wr_val,
    output logic                  ssid_rd,
    output logic [SSIDBITS-1:0]   ssid_rd_val,
    output logic                  active,
    output logic                  done,
    output logic [15:0]           cmd_count
);

    localparam int unsigned N_ALT   = NROWS * NCOLS;
    localparam int unsigned N_SWEEP = SWEEP_LAST + 1;
    localparam int unsigned N_MAX_A = (N_ALT > N_SWEEP) ? N_ALT : N_SWEEP;
    localparam int unsigned N_MAX_B = (NROWS > LISTDEPTH) ? NROWS : LISTDEPTH;
    localparam int unsigned N_MAX   = (N_MAX_A > N_MAX_B) ? N_MAX_A : N_MAX_B;
    localparam int IDXW  = $clog2(N_MAX + 1);
    localparam int LENW  = LISTBITS + 1;
    localparam int SSIDW = ROWBITS + COLBITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [2:0]          mode_q, mode_d;
    logic [LENW-1:0]     len_q, len_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                row_rd_q, row_rd_d, row_wr_q, row_wr_d;
    logic                ssid_wr_q, ssid_wr_d, ssid_rd_q, ssid_rd_d;
    logic                active_q, active_d, done_q, done_d;
    logic [ROWBITS-1:0]  row_rd_idx_q, row_rd_idx_d, row_wr_idx_q, row_wr_idx_d;
    logic [NCOLS-1:0]    row_wr_data_q, row_wr_data_d;
    logic [SSIDW-1:0]    ssid_wr_val_q, ssid_wr_val_d, ssid_rd_val_q, ssid_rd_val_d;

    logic [SSIDBITS-1:0] list_mem [LISTDEPTH];
    logic [SSIDBITS-1:0] list_rd_s;
    logic                in_idle_s, launch_s, issue_s, strobe_s;
    logic [2:0]          eff_mode_s;
    logic [LENW-1:0]     eff_len_s;
    logic [IDXW-1:0]     cur_idx_s, n_items_s;

    function automatic logic [LENW-1:0] clamp_len(input logic [LENW-1:0] len);
        logic [LENW-1:0] r;
        if (len > LENW'(LISTDEPTH)) begin
            r = LENW'(LISTDEPTH);
        end else begin
            r = len;
        end
        return r;
    endfunction

    function automatic logic [IDXW-1:0] item_count(input logic [2:0] m, input logic [LENW-1:0] len);
        logic [IDXW-1:0] n;
        case (m)
            3'd1, 3'd3, 3'd5, 3'd7: n = IDXW'(NROWS);
            3'd2:                   n = IDXW'(N_ALT);
            3'd4:                   n = IDXW'(N_SWEEP);
            3'd6:                   n = IDXW'(len);
            default:                n = {IDXW{1'b0}};
        endcase
        return n;
    endfunction

    // Bit k is set when k and the row index have the same parity.
    function automatic logic [NCOLS-1:0] checker_row(input logic row_odd);
        logic [NCOLS-1:0] r;
        for (int k = 0; k < NCOLS; k++) begin
            r[k] = ((k % 2) == 0) ? ~row_odd : row_odd;
        end
        return r;
    endfunction

    // List RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (list_wr_en) begin
            list_mem[list_wr_addr] <= list_wr_data;
        end
    end

    // The launch cycle issues item 0 straight from the live mode/len inputs.
    always_comb begin
        in_idle_s = (state_q == S_IDLE);
        launch_s  = in_idle_s && start && (mode != 3'd0) && !abort;
        if (in_idle_s) begin
            eff_mode_s = mode;
            eff_len_s  = clamp_len(list_len);
            cur_idx_s  = {IDXW{1'b0}};
        end else begin
            eff_mode_s = mode_q;
            eff_len_s  = len_q;
            cur_idx_s  = idx_q;
        end
        n_items_s = item_count(eff_mode_s, eff_len_s);
        issue_s   = (launch_s || ((state_q == S_RUN) && !abort)) && !hnm_busy && (cur_idx_s < n_items_s);
        list_rd_s = list_mem[cur_idx_s[LISTBITS-1:0]];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and run bookkeeping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (launch_s) begin
                    mode_d = mode;
                    len_d  = eff_len_s;
                    idx_d  = issue_s ? IDXW'(1) : {IDXW{1'b0}};
                    if (n_items_s == {IDXW{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue_s) begin
                    idx_d = idx_q + IDXW'(1);
                end else begin
                    idx_d = idx_q;
                end
                // Busy never holds off completion once every item has been issued.
                if (abort || (idx_q >= n_items_s)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command decode for the item being issued this cycle.
    always_comb begin
        row_rd_d      = 1'b0;
        row_rd_idx_d  = {ROWBITS{1'b0}};
        row_wr_d      = 1'b0;
        row_wr_idx_d  = {ROWBITS{1'b0}};
        row_wr_data_d = {NCOLS{1'b0}};
        ssid_wr_d     = 1'b0;
        ssid_wr_val_d = {SSIDW{1'b0}};
        ssid_rd_d     = 1'b0;
        ssid_rd_val_d = {SSIDW{1'b0}};
        active_d      = (state_d == S_RUN);
        done_d        = (state_d == S_DONE);
        if (issue_s) begin
            case (eff_mode_s)
                3'd1: begin
                    row_rd_d     = 1'b1;
                    row_rd_idx_d = ROWBITS'(cur_idx_s);
                end
                3'd2: begin
                    if (cur_idx_s[0]) begin
                        ssid_wr_d     = 1'b1;
                        ssid_wr_val_d = SSIDW'(cur_idx_s);
                    end else begin
                        ssid_wr_d     = 1'b0;
                    end
                end
                3'd3: begin
                    row_wr_d      = 1'b1;
                    row_wr_idx_d  = ROWBITS'(cur_idx_s);
                    row_wr_data_d = NCOLS'(cur_idx_s);
                end
                3'd4: begin
                    ssid_rd_d     = 1'b1;
                    ssid_rd_val_d = SSIDW'(cur_idx_s);
                end
                3'd5: begin
                    row_wr_d      = 1'b1;
                    row_wr_idx_d  = ROWBITS'(cur_idx_s);
                    row_wr_data_d = checker_row(cur_idx_s[0]);
                end
                3'd6: begin
                    ssid_wr_d     = 1'b1;
                    ssid_wr_val_d = list_rd_s;
                end
                3'd7: begin
                    row_wr_d      = 1'b1;
                    row_wr_idx_d  = ROWBITS'(cur_idx_s);
                end
                default: row_rd_d = 1'b0;
            endcase
        end else begin
            row_rd_d = 1'b0;
        end
        strobe_s = row_rd_d | row_wr_d | ssid_wr_d | ssid_rd_d;
        if (launch_s) begin
            cnt_d = strobe_s ? 16'd1 : 16'd0;
        end else if (strobe_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q         <= {IDXW{1'b0}};
            mode_q        <= 3'd0;
            len_q         <= {LENW{1'b0}};
            cnt_q         <= 16'd0;
            row_rd_q      <= 1'b0;
            row_rd_idx_q  <= {ROWBITS{1'b0}};
            row_wr_q      <= 1'b0;
            row_wr_idx_q  <= {ROWBITS{1'b0}};
            row_wr_data_q <= {NCOLS{1'b0}};
            ssid_wr_q     <= 1'b0;
            ssid_wr_val_q <= {SSIDW{1'b0}};
            ssid_rd_q     <= 1'b0;
            ssid_rd_val_q <= {SSIDW{1'b0}};
            active_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            mode_q        <= mode_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            row_rd_q      <= row_rd_d;
            row_rd_idx_q  <= row_rd_idx_d;
            row_wr_q      <= row_wr_d;
            row_wr_idx_q  <= row_wr_idx_d;
            row_wr_data_q <= row_wr_data_d;
            ssid_wr_q     <= ssid_wr_d;
            ssid_wr_val_q <= ssid_wr_val_d;
            ssid_rd_q     <= ssid_rd_d;
            ssid_rd_val_q <= ssid_rd_val_d;
            active_q      <= active_d;
            done_q        <= done_d;
        end
    end

    assign row_rd      = row_rd_q;
    assign row_rd_idx  = row_rd_idx_q;
    assign row_wr      = row_wr_q;
    assign row_wr_idx  = row_wr_idx_q;
    assign row_wr_data = row_wr_data_q;
    assign ssid_wr     = ssid_wr_q;
    assign ssid_wr_val = ssid_wr_val_q;
    assign ssid_rd     = ssid_rd_q;
    assign ssid_rd_val = ssid_rd_val_q;
    assign active      = active_q;
    assign done        = done_q;
    assign cmd_count   = cnt_q;

endmodule

// File: tb/tb_hnm_test_sequencer.sv
// Randomised and directed bench for hnm_test_sequencer against a queue-based
// model of the expected command stream.
module tb_hnm_test_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mode;
    logic        abort;
    logic        hnm_busy;
    logic        list_wr_en;
    logic [4:0]  list_wr_addr;
    logic [7:0]  list_wr_data;
    logic [5:0]  list_len;
    logic        row_rd, row_wr, ssid_wr, ssid_rd, active, done;
    logic [3:0]  row_rd_idx, row_wr_idx;
    logic [15:0] row_wr_data;
    logic [7:0]  ssid_wr_val, ssid_rd_val;
    logic [15:0] cmd_count;

    hnm_test_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .hnm_busy(hnm_busy), .list_wr_en(list_wr_en), .list_wr_addr(list_wr_addr),
        .list_wr_data(list_wr_data), .list_len(list_len),
        .row_rd(row_rd), .row_rd_idx(row_rd_idx), .row_wr(row_wr), .row_wr_idx(row_wr_idx),
        .row_wr_data(row_wr_data), .ssid_wr(ssid_wr), .ssid_wr_val(ssid_wr_val),
        .ssid_rd(ssid_rd), .ssid_rd_val(ssid_rd_val), .active(active), .done(done),
        .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: a queue of pending items (kind<<16 | value), plus run/done flags.
    logic [7:0] m_list [32];
    int  m_q[$];
    bit  m_run, m_done_now;
    int  m_cnt;
    bit  e_rr, e_rw, e_sw, e_sr, e_act, e_done;
    int  e_rr_idx, e_rw_idx, e_rw_data, e_sw_val, e_sr_val;

    task automatic model_reset();
        m_q.delete();
        m_run = 1'b0; m_done_now = 1'b0; m_cnt = 0;
        e_rr = 1'b0; e_rw = 1'b0; e_sw = 1'b0; e_sr = 1'b0; e_act = 1'b0; e_done = 1'b0;
    endtask

    task automatic model_load(input int md, input int ln);
        int n;
        m_q.delete();
        n = (ln > 32) ? 32 : ln;
        case (md)
            1: for (int i = 0; i < 16; i++)  m_q.push_back((1 << 16) | i);
            2: for (int i = 0; i < 256; i++) m_q.push_back((i % 2 == 1) ? ((3 << 16) | i) : 0);
            3: for (int i = 0; i < 16; i++)  m_q.push_back((2 << 16) | i);
            4: for (int i = 0; i < 256; i++) m_q.push_back((4 << 16) | i);
            5: for (int i = 0; i < 16; i++)  m_q.push_back((5 << 16) | i);
            6: for (int i = 0; i < n; i++)   m_q.push_back((7 << 16) | i);
            7: for (int i = 0; i < 16; i++)  m_q.push_back((6 << 16) | i);
            default: m_q.delete();
        endcase
    endtask

    task automatic model_issue();
        int it, kind, v;
        it = m_q.pop_front();
        kind = it >> 16;
        v = it & 32'hFFFF;
        case (kind)
            1: begin e_rr = 1'b1; e_rr_idx = v; end
            2: begin e_rw = 1'b1; e_rw_idx = v; e_rw_data = v; end
            3: begin e_sw = 1'b1; e_sw_val = v; end
            4: begin e_sr = 1'b1; e_sr_val = v; end
            5: begin e_rw = 1'b1; e_rw_idx = v; e_rw_data = (v % 2 == 0) ? 32'h5555 : 32'hAAAA; end
            6: begin e_rw = 1'b1; e_rw_idx = v; e_rw_data = 0; end
            7: begin e_sw = 1'b1; e_sw_val = int'(m_list[v[4:0]]); end
            default: e_rr = 1'b0;
        endcase
        if ((e_rr || e_rw || e_sw || e_sr) && m_cnt < 65535) m_cnt++;
    endtask

    // Predict the outputs seen after the coming clock edge from this cycle's inputs.
    task automatic model_step(input bit st, input int md, input bit ab, input bit bz,
                              input bit we, input int wa, input int wd, input int ln);
        e_rr = 1'b0; e_rw = 1'b0; e_sw = 1'b0; e_sr = 1'b0; e_act = 1'b0; e_done = 1'b0;
        if (m_done_now) begin
            m_done_now = 1'b0;
        end else if (!m_run) begin
            if (st && md != 0 && !ab) begin
                model_load(md, ln);
                m_cnt = 0;
                if (m_q.size() == 0) begin
                    e_done = 1'b1; m_done_now = 1'b1;
                end else begin
                    m_run = 1'b1; e_act = 1'b1;
                    if (!bz) model_issue();
                end
            end
        end else begin
            if (ab || m_q.size() == 0) begin
                e_done = 1'b1; m_done_now = 1'b1; m_run = 1'b0;
            end else begin
                e_act = 1'b1;
                if (!bz) model_issue();
            end
        end
        if (we) m_list[wa[4:0]] = 8'(wd);
    endtask

    task automatic compare();
        chk("active", active, e_act);
        chk("done", done, e_done);
        chk("row_rd", row_rd, e_rr);
        chk("row_wr", row_wr, e_rw);
        chk("ssid_wr", ssid_wr, e_sw);
        chk("ssid_rd", ssid_rd, e_sr);
        chk("cmd_count", cmd_count, m_cnt);
        if (e_rr) chk("row_rd_idx", row_rd_idx, e_rr_idx);
        if (e_rw) chk("row_wr_idx", row_wr_idx, e_rw_idx);
        if (e_rw) chk("row_wr_data", row_wr_data, e_rw_data);
        if (e_sw) chk("ssid_wr_val", ssid_wr_val, e_sw_val);
        if (e_sr) chk("ssid_rd_val", ssid_rd_val, e_sr_val);
    endtask

    task automatic cycle(input logic st, input logic [2:0] md, input logic ab, input logic bz,
                         input logic we, input logic [4:0] wa, input logic [7:0] wd, input logic [5:0] ln);
        start = st; mode = md; abort = ab; hnm_busy = bz;
        list_wr_en = we; list_wr_addr = wa; list_wr_data = wd; list_len = ln;
        model_step(st, int'(md), ab, bz, we, int'(wa), int'(wd), int'(ln));
        @(posedge clk);
        #1;
        compare();
    endtask

    // done_k: cycle offset from the start cycle at which done was observed (-1 if never).
    task automatic run(input logic [2:0] md, input logic [5:0] ln, input int busy_at, input int busy_len,
                       input int abort_at, input bit rnd, output int done_k);
        int k;
        logic st, ab, bz, we;
        logic [4:0] wa;
        logic [7:0] wd;
        k = 0;
        done_k = -1;
        while (k < 3000) begin
            st = (k == 0);
            ab = (k == abort_at);
            bz = (k >= busy_at) && (k < busy_at + busy_len);
            we = 1'b0; wa = 5'd0; wd = 8'd0;
            if (rnd && k > 0) begin
                bz = ($urandom_range(3) == 0);
                ab = ($urandom_range(99) == 0);
                st = 1'($urandom_range(1));
                we = ($urandom_range(7) == 0);
                wa = 5'($urandom);
                wd = 8'($urandom);
            end
            cycle(st, md, ab, bz, we, wa, wd, ln);
            if (done && done_k < 0) done_k = k + 1;
            k++;
            if (!m_run && !m_done_now) break;
        end
        if (k >= 3000) chk("run_timeout", k, 0);
    endtask

    logic [7:0] seed_list [4];

    initial begin
        int dk;
        reset = 1'b1; start = 1'b0; mode = 3'd0; abort = 1'b0; hnm_busy = 1'b0;
        list_wr_en = 1'b0; list_wr_addr = 5'd0; list_wr_data = 8'd0; list_len = 6'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        reset = 1'b0;

        seed_list[0] = 8'h80; seed_list[1] = 8'h83; seed_list[2] = 8'h87; seed_list[3] = 8'h88;
        for (int i = 0; i < 32; i++)
            cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 5'(i), (i < 4) ? seed_list[i] : 8'($urandom), 6'd0);

        run(3'd1, 6'd0, -10, 0, -1, 1'b0, dk);
        chk("m1_done_at", dk, 17);
        chk("m1_count", cmd_count, 16);

        run(3'd5, 6'd0, 6, 3, -1, 1'b0, dk);
        chk("m5_done_at", dk, 20);
        chk("m5_count", cmd_count, 16);

        run(3'd6, 6'd4, -10, 0, -1, 1'b0, dk);
        chk("m6_done_at", dk, 5);
        chk("m6_count", cmd_count, 4);

        run(3'd6, 6'd0, -10, 0, -1, 1'b0, dk);
        chk("m6_len0_done_at", dk, 1);
        chk("m6_len0_count", cmd_count, 0);

        run(3'd2, 6'd0, -10, 0, -1, 1'b0, dk);
        chk("m2_done_at", dk, 257);
        chk("m2_count", cmd_count, 128);

        run(3'd4, 6'd0, -10, 0, 5, 1'b0, dk);
        chk("m4_abort_done_at", dk, 6);
        chk("m4_abort_count", cmd_count, 5);

        run(3'd0, 6'd0, -10, 0, -1, 1'b0, dk);
        chk("m0_no_done", dk, -1);
        chk("m0_active", active, 0);

        cycle(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 6'd0);
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 6'd0);

        cycle(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 6'd0);
        repeat (5) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 6'd0);
        #2 reset = 1'b1;
        #1;
        chk("rst_row_wr", row_wr, 0);
        chk("rst_row_wr_idx", row_wr_idx, 0);
        chk("rst_row_wr_data", row_wr_data, 0);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        chk("rst_count", cmd_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        compare();

        run(3'd1, 6'd0, -10, 0, -1, 1'b0, dk);
        chk("m1_fresh_done_at", dk, 17);
        chk("m1_fresh_count", cmd_count, 16);

        for (int r = 0; r < 24; r++)
            run(3'($urandom_range(7)), 6'($urandom_range(40)), -10, 0, -1, 1'b1, dk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
